// File: rtl/cpu_datapath.sv
// cpu_datapath: four-state multi-cycle register-file datapath (IDLE/READ/EXEC/WB) with a CLR sweep.
// Build option: define CPU_DATAPATH_MUL_EN to enable op 101 MUL; otherwise MUL raises the sticky err.
// Ports:
//   clk, rst (async, active-high)
//   in_valid/in_ready     instruction handshake; in_ready only in IDLE
//   op, dst, src1, src2, imm  instruction fields, registered on capture
//   res_valid             one-cycle completion pulse (WB cycle, or last CLR cycle of a CLR instruction)
//   res_op, res_dst, res_value  completed instruction info; values hold between pulses
//   flag_z, flag_n, flag_v      zero, negative and signed-overflow flags
//   err                   sticky illegal-opcode flag, cleared only by rst
module cpu_datapath #(
  parameter int DW = 16,
  parameter int NREG = 16,
  parameter int IMMW = 7,
  localparam int AW = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    op,
  input  logic [AW-1:0] dst,
  input  logic [AW-1:0] src1,
  input  logic [AW-1:0] src2,
  input  logic [IMMW-1:0] imm,
  output logic          res_valid,
  output logic [2:0]    res_op,
  output logic [AW-1:0] res_dst,
  output logic [DW-1:0] res_value,
  output logic          flag_z,
  output logic          flag_n,
  output logic          flag_v,
  output logic          err
);
  localparam logic [2:0] S_CLR = 3'd0, S_IDLE = 3'd1, S_READ = 3'd2, S_EXEC = 3'd3, S_WB = 3'd4;
  localparam logic [2:0] OP_LOAD = 3'd0, OP_ADD = 3'd1, OP_ADDI = 3'd2, OP_SUB = 3'd3;
  localparam logic [2:0] OP_SUBI = 3'd4, OP_MUL = 3'd5, OP_CLR = 3'd6, OP_DISP = 3'd7;
`ifdef CPU_DATAPATH_MUL_EN
  localparam logic MUL_OK = 1'b1;
`else
  localparam logic MUL_OK = 1'b0;
`endif
  logic [2:0]      state_q, state_d;
  logic [AW-1:0]   cnt_q;
  logic            user_clr_q;
  logic [2:0]      op_q;
  logic [AW-1:0]   dst_q, src1_q, src2_q;
  logic [IMMW-1:0] imm_q;
  logic [DW-1:0]   a_q, b_q;
  logic            wr_q;
  logic            res_valid_q;
  logic [2:0]      res_op_q;
  logic [AW-1:0]   res_dst_q;
  logic [DW-1:0]   res_value_q;
  logic            z_q, n_q, v_q, err_q;
  logic [DW-1:0]   regs [NREG];
  logic [DW-1:0]   sext, opb, sum, diff, prod, result;
  logic            is_add, is_sub, ovf, upd, bad, capture, clr_last_next;
  assign in_ready  = state_q == S_IDLE;
  assign capture   = in_ready && in_valid;
  assign res_valid = res_valid_q;
  assign res_op    = res_op_q;
  assign res_dst   = res_dst_q;
  assign res_value = res_value_q;
  assign flag_z    = z_q;
  assign flag_n    = n_q;
  assign flag_v    = v_q;
  assign err       = err_q;
  // The completion pulse of a CLR instruction lands on the last sweep cycle, so it is armed one cycle early.
  assign clr_last_next = state_q == S_CLR && user_clr_q && cnt_q == AW'(NREG - 2);
  always_comb begin
    state_d = state_q == S_IDLE ? (in_valid ? (op == OP_CLR ? S_CLR : S_READ) : S_IDLE)
            : state_q == S_READ ? S_EXEC
            : state_q == S_EXEC ? S_WB
            : state_q == S_WB   ? S_IDLE
            : cnt_q == AW'(NREG - 1) ? S_IDLE : S_CLR;
  end
  always_comb begin
    sext   = {{(DW-IMMW){imm_q[IMMW-1]}}, imm_q};
    is_add = op_q == OP_ADD || op_q == OP_ADDI;
    is_sub = op_q == OP_SUB || op_q == OP_SUBI;
    opb    = (op_q == OP_ADDI || op_q == OP_SUBI) ? sext : b_q;
    sum    = a_q + opb;
    diff   = a_q - opb;
    prod   = MUL_OK ? a_q * b_q : '0;
    result = op_q == OP_LOAD ? sext
           : is_add ? sum
           : is_sub ? diff
           : op_q == OP_MUL ? prod
           : op_q == OP_DISP ? a_q : '0;
    // Signed overflow: add of like signs, or subtract of unlike signs, whose result sign differs from a.
    ovf    = is_add ? (a_q[DW-1] == opb[DW-1] && sum[DW-1] != a_q[DW-1])
           : is_sub ? (a_q[DW-1] != opb[DW-1] && diff[DW-1] != a_q[DW-1]) : 1'b0;
    upd    = op_q <= OP_SUBI || (op_q == OP_MUL && MUL_OK);
    bad    = op_q == OP_MUL && !MUL_OK;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_CLR;
      cnt_q       <= '0;
      user_clr_q  <= 1'b0;
      op_q        <= '0;
      dst_q       <= '0;
      src1_q      <= '0;
      src2_q      <= '0;
      imm_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      wr_q        <= 1'b0;
      res_valid_q <= 1'b0;
      res_op_q    <= '0;
      res_dst_q   <= '0;
      res_value_q <= '0;
      z_q         <= 1'b0;
      n_q         <= 1'b0;
      v_q         <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= state_q == S_CLR ? cnt_q + 1'b1 : '0;
      user_clr_q  <= (capture && op == OP_CLR) || (state_q == S_CLR && user_clr_q && state_d == S_CLR);
      res_valid_q <= state_q == S_EXEC || clr_last_next;
      if (capture) begin
        op_q   <= op;
        dst_q  <= dst;
        src1_q <= src1;
        src2_q <= src2;
        imm_q  <= imm;
      end
      if (state_q == S_READ) begin
        a_q <= regs[src1_q];
        b_q <= regs[src2_q];
      end
      if (state_q == S_EXEC) begin
        res_op_q    <= op_q;
        res_dst_q   <= dst_q;
        res_value_q <= result;
        wr_q        <= upd;
        if (upd) begin
          z_q <= result == '0;
          n_q <= result[DW-1];
          v_q <= ovf;
        end
        if (bad) err_q <= 1'b1;
      end
      if (clr_last_next) begin
        res_op_q    <= op_q;
        res_dst_q   <= dst_q;
        res_value_q <= '0;
        z_q         <= 1'b1;
        n_q         <= 1'b0;
        v_q         <= 1'b0;
      end
    end
  end
  // Writes depend only on state, which rst forces to CLR asynchronously, so a pending WB write is dropped.
  always_ff @(posedge clk) begin
    if (state_q == S_CLR) regs[cnt_q] <= '0;
    else if (state_q == S_WB && wr_q) regs[dst_q] <= res_value_q;
  end
endmodule

// File: tb/tb_cpu_datapath.sv
// tb_cpu_datapath: directed self-checking bench for cpu_datapath (DW=16, NREG=16, IMMW=7).
module tb_cpu_datapath;
  logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0;
  logic [2:0]  op = '0;
  logic [3:0]  dst = '0, src1 = '0, src2 = '0;
  logic [6:0]  imm = '0;
  logic        in_ready, res_valid, flag_z, flag_n, flag_v, err;
  logic [2:0]  res_op;
  logic [3:0]  res_dst;
  logic [15:0] res_value;
  int          n_chk = 0, n_fail = 0;
  int          lat, pulses, k;
  logic [15:0] val;
  logic        z, nn, vv, ee;
  cpu_datapath dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .dst(dst),
    .src1(src1), .src2(src2), .imm(imm), .res_valid(res_valid), .res_op(res_op),
    .res_dst(res_dst), .res_value(res_value), .flag_z(flag_z), .flag_n(flag_n),
    .flag_v(flag_v), .err(err)
  );
  always #5 clk = ~clk;
  // Issues one instruction from a negedge, returns at the negedge where in_ready is back.
  // lat = negedges after the capture edge at which the first res_valid pulse was seen.
  task automatic issue(input logic [2:0] o, input logic [3:0] d, s1, s2, input logic [6:0] im);
    int w;
    w = 0;
    lat = 0;
    pulses = 0;
    val = '0;
    {z, nn, vv} = '0;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    op = o; dst = d; src1 = s1; src2 = s2; imm = im; in_valid = 1'b1;
    @(posedge clk);
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (res_valid) begin
        pulses++;
        if (lat == 0) begin
          lat = j;
          val = res_value;
          {z, nn, vv} = {flag_z, flag_n, flag_v};
        end
      end
      if (in_ready) break;
    end
    ee = err;
  endtask
  task automatic wait_clr();
    k = 0;
    pulses = 0;
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
      if (res_valid) pulses++;
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({in_ready, res_valid, res_op, res_dst, res_value, flag_z, flag_n, flag_v, err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b op=%h dst=%h val=%h zn v=%b%b%b err=%b, want all 0",
               in_ready, res_valid, res_op, res_dst, res_value, flag_z, flag_n, flag_v, err);
    end
    rst = 1'b0;
    wait_clr();
    n_chk++;
    if (k !== 16) begin n_fail++; $display("FAIL reset_clr_len: got %0d cycles, want 16", k); end
    n_chk++;
    if (pulses !== 0) begin n_fail++; $display("FAIL reset_clr_pulse: got %0d pulses, want 0", pulses); end
    for (int r = 0; r < 16; r++) begin
      issue(3'd7, 4'd0, 4'(r), 4'd0, 7'd0);
      n_chk++;
      if (val !== 16'h0 || lat !== 3) begin
        n_fail++;
        $display("FAIL reset_disp_r%0d: got val=%h lat=%0d, want val=0000 lat=3", r, val, lat);
      end
    end
  endtask
  task automatic test_load();
    issue(3'd0, 4'd1, 4'd0, 4'd0, 7'h7F);
    n_chk++;
    if ({val, z, nn, vv} !== {16'hFFFF, 3'b010} || lat !== 3 || pulses !== 1) begin
      n_fail++;
      $display("FAIL load_neg: got val=%h znv=%b%b%b lat=%0d pulses=%0d, want ffff 010 3 1", val, z, nn, vv, lat, pulses);
    end
    n_chk++;
    if ({res_op, res_dst} !== {3'd0, 4'd1}) begin
      n_fail++;
      $display("FAIL load_tag: got op=%h dst=%h, want op=0 dst=1", res_op, res_dst);
    end
    issue(3'd7, 4'd0, 4'd1, 4'd0, 7'd0);
    n_chk++;
    if ({val, z, nn, vv} !== {16'hFFFF, 3'b010} || lat !== 3) begin
      n_fail++;
      $display("FAIL disp_r1: got val=%h znv=%b%b%b lat=%0d, want ffff 010 3", val, z, nn, vv, lat);
    end
  endtask
  task automatic test_arith();
    issue(3'd0, 4'd2, 4'd0, 4'd0, 7'h3F);
    n_chk++;
    if (val !== 16'd63) begin n_fail++; $display("FAIL load_63: got %0d, want 63", val); end
    issue(3'd2, 4'd3, 4'd2, 4'd0, 7'h3F);
    n_chk++;
    if (val !== 16'd126) begin n_fail++; $display("FAIL addi_126: got %0d, want 126", val); end
    issue(3'd1, 4'd3, 4'd3, 4'd3, 7'd0);
    n_chk++;
    if ({val, z, nn, vv} !== {16'd252, 3'b000}) begin
      n_fail++;
      $display("FAIL add_252: got %0d znv=%b%b%b, want 252 000", val, z, nn, vv);
    end
  endtask
  task automatic test_overflow();
    issue(3'd0, 4'd4, 4'd0, 4'd0, 7'd1);
    repeat (14) issue(3'd1, 4'd4, 4'd4, 4'd4, 7'd0);
    n_chk++;
    if (val !== 16'h4000) begin n_fail++; $display("FAIL dbl_4000: got %h, want 4000", val); end
    issue(3'd2, 4'd5, 4'd4, 4'd0, 7'h7F);
    n_chk++;
    if (val !== 16'h3FFF) begin n_fail++; $display("FAIL addi_m1: got %h, want 3fff", val); end
    issue(3'd1, 4'd4, 4'd4, 4'd5, 7'd0);
    n_chk++;
    if ({val, z, nn, vv} !== {16'h7FFF, 3'b000}) begin
      n_fail++;
      $display("FAIL add_7fff: got %h znv=%b%b%b, want 7fff 000", val, z, nn, vv);
    end
    issue(3'd2, 4'd4, 4'd4, 4'd0, 7'd1);
    n_chk++;
    if ({val, z, nn, vv} !== {16'h8000, 3'b011}) begin
      n_fail++;
      $display("FAIL addi_ovf: got %h znv=%b%b%b, want 8000 011", val, z, nn, vv);
    end
    issue(3'd3, 4'd5, 4'd4, 4'd4, 7'd0);
    n_chk++;
    if ({val, z, nn, vv} !== {16'h0000, 3'b100}) begin
      n_fail++;
      $display("FAIL sub_zero: got %h znv=%b%b%b, want 0000 100", val, z, nn, vv);
    end
    issue(3'd4, 4'd6, 4'd4, 4'd0, 7'd1);
    n_chk++;
    if ({val, z, nn, vv} !== {16'h7FFF, 3'b001}) begin
      n_fail++;
      $display("FAIL subi_ovf: got %h znv=%b%b%b, want 7fff 001", val, z, nn, vv);
    end
  endtask
  task automatic test_mul();
    issue(3'd5, 4'd6, 4'd2, 4'd2, 7'd0);
`ifdef CPU_DATAPATH_MUL_EN
    n_chk++;
    if ({val, z, nn, vv, ee} !== {16'd3969, 4'b0000} || lat !== 3) begin
      n_fail++;
      $display("FAIL mul_on: got %0d znv=%b%b%b err=%b lat=%0d, want 3969 000 0 3", val, z, nn, vv, ee, lat);
    end
    issue(3'd7, 4'd0, 4'd6, 4'd0, 7'd0);
    n_chk++;
    if (val !== 16'd3969) begin n_fail++; $display("FAIL mul_on_r6: got %0d, want 3969", val); end
`else
    n_chk++;
    if ({val, z, nn, vv, ee} !== {16'd0, 4'b0011} || lat !== 3 || pulses !== 1) begin
      n_fail++;
      $display("FAIL mul_off: got %h znv=%b%b%b err=%b lat=%0d, want 0000 001 1 3", val, z, nn, vv, ee, lat);
    end
    issue(3'd7, 4'd0, 4'd6, 4'd0, 7'd0);
    n_chk++;
    if (val !== 16'h7FFF || err !== 1'b1) begin
      n_fail++;
      $display("FAIL mul_off_r6: got %h err=%b, want 7fff err=1", val, err);
    end
`endif
  endtask
  task automatic test_back_to_back();
    issue(3'd0, 4'd7, 4'd0, 4'd0, 7'd5);
    issue(3'd1, 4'd8, 4'd7, 4'd7, 7'd0);
    n_chk++;
    if (val !== 16'd10) begin n_fail++; $display("FAIL b2b_add: got %0d, want 10", val); end
    issue(3'd2, 4'd7, 4'd7, 4'd0, 7'd3);
    issue(3'd7, 4'd0, 4'd7, 4'd0, 7'd0);
    n_chk++;
    if (val !== 16'd8) begin n_fail++; $display("FAIL self_addi: got %0d, want 8", val); end
  endtask
  task automatic test_ignore();
    pulses = 0;
    op = 3'd0; dst = 4'd9; imm = 7'd5; in_valid = 1'b1;
    @(posedge clk);
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      dst = 4'd10; imm = 7'd9;
      if (j == 3) in_valid = 1'b0;
      if (res_valid) pulses++;
    end
    n_chk++;
    if (pulses !== 1 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_ignore: got pulses=%0d rdy=%b, want 1 1", pulses, in_ready);
    end
    issue(3'd7, 4'd0, 4'd9, 4'd0, 7'd0);
    n_chk++;
    if (val !== 16'd5) begin n_fail++; $display("FAIL busy_r9: got %0d, want 5", val); end
    issue(3'd7, 4'd0, 4'd10, 4'd0, 7'd0);
    n_chk++;
    if (val !== 16'd0) begin n_fail++; $display("FAIL busy_r10: got %0d, want 0", val); end
  endtask
  task automatic test_clr();
    issue(3'd6, 4'd0, 4'd0, 4'd0, 7'd0);
    n_chk++;
    if ({val, z, nn, vv} !== {16'd0, 3'b100} || lat !== 16 || pulses !== 1 || res_op !== 3'd6) begin
      n_fail++;
      $display("FAIL clr_done: got val=%h znv=%b%b%b lat=%0d pulses=%0d op=%h, want 0000 100 16 1 6",
               val, z, nn, vv, lat, pulses, res_op);
    end
    issue(3'd7, 4'd0, 4'd3, 4'd0, 7'd0);
    n_chk++;
    if (val !== 16'd0) begin n_fail++; $display("FAIL clr_r3: got %h, want 0000", val); end
    issue(3'd7, 4'd0, 4'd9, 4'd0, 7'd0);
    n_chk++;
    if (val !== 16'd0) begin n_fail++; $display("FAIL clr_r9: got %h, want 0000", val); end
  endtask
  task automatic test_abort();
    issue(3'd0, 4'd1, 4'd0, 4'd0, 7'd7);
    op = 3'd1; dst = 4'd1; src1 = 4'd1; src2 = 4'd1; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_chk++;
    if ({in_ready, res_valid, err, res_value} !== '0) begin
      n_fail++;
      $display("FAIL abort_rst: got rdy=%b vld=%b err=%b val=%h, want 0 0 0 0000", in_ready, res_valid, err, res_value);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_clr();
    n_chk++;
    if (k !== 16 || pulses !== 0) begin
      n_fail++;
      $display("FAIL abort_clr: got %0d cycles %0d pulses, want 16 0", k, pulses);
    end
    issue(3'd7, 4'd0, 4'd1, 4'd0, 7'd0);
    n_chk++;
    if (val !== 16'd0) begin n_fail++; $display("FAIL abort_r1: got %h, want 0000", val); end
  endtask
  initial begin
    test_reset();
    test_load();
    test_arith();
    test_overflow();
    test_mul();
    test_back_to_back();
    test_ignore();
    test_clr();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
